vram_port_arbiter: RTL
======================

# vram_port_arbiter

Time-multiplexes the single-port 32 KiB video RAM between the video scan-out engine and the CPU bus. Sits directly upstream of the video chip: it serves the video chip's RAM address/data port on every even `clk` cycle. CPU reads and writes are queued and executed on odd cycles. Video fetch bandwidth is never reduced; CPU accesses tolerate a short, bounded latency.

## Interface
- `ADDR_W`, 15: VRAM address width (0000–7FFF).
- `DATA_W`, 8: VRAM data width.
- `FIFO_DEPTH`, 4: CPU command queue depth (power of two, ≥2).

Ports:
- `clk`  in  1: system clock, 2× the pixel clock; the video chip's pixel clock is `clk`/2.
- `rst`  in  1: synchronous, active-high reset.
- `vid_phase`  out  1: 0 = video slot, 1 = CPU slot; toggles every `clk`.
- `vid_addr`  in  ADDR_W: video chip read address.
- `vid_data`  out  DATA_W: registered video read data.
- `cpu_valid`  in  1: CPU command request.
- `cpu_rd`  in  1: 1 = read, 0 = write; qualified by `cpu_valid`.
- `cpu_addr`  in  ADDR_W: CPU address.
- `cpu_wdata`  in  DATA_W: CPU write data.
- `cpu_ready`  out  1: command accepted when `cpu_valid & cpu_ready`.
- `cpu_rd_valid`  out  1: one-cycle pulse; `cpu_rd_data` is valid.
- `cpu_rd_data`  out  DATA_W: read return data.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1: queued command count.
- `ram_addr`  out  ADDR_W: RAM address.
- `ram_wdata`  out  DATA_W: RAM write data.
- `ram_we`  out  1: RAM write enable.
- `ram_rdata`  in  DATA_W: RAM read data. The RAM has synchronous read, so data appears the cycle after its address.

## Operation
- `phase` register: reset 0, then toggles every cycle. It drives `vid_phase`.
- Video slot (phase 0):
  - `ram_addr = vid_addr`, `ram_we = 0`.
  - Unconditional; CPU traffic never displaces it.
- CPU slot (phase 1):
  - If the FIFO is non-empty, pop the head command and drive its address.
  - Write command: `ram_we = 1` and `ram_wdata = data`.
  - Read command: `ram_we = 0`; set `rd_pending`.
  - If the FIFO is empty: `ram_addr` holds its last value and `ram_we = 0`.
- Video data capture: at the end of each phase-1 cycle, `vid_data <= ram_rdata`. This captures the result of the preceding phase-0 address.
- CPU read return: at the end of the phase-0 cycle following a read issue, `cpu_rd_data <= ram_rdata` and `cpu_rd_valid <= 1`. `cpu_rd_valid` is cleared after one cycle.
- Ordering:
  - One FIFO holds both reads and writes, so commands execute in acceptance order.
  - A read after a write to the same address returns the new data.
- `cpu_ready = !rst & (fifo_level < FIFO_DEPTH)`.
- Push and pop in the same cycle: the level is unchanged.
- A push into an empty FIFO is not bypassed. The command executes in the next CPU slot after the push edge.
- Full FIFO: `cpu_ready = 0`; the CPU holds `cpu_valid`, `cpu_rd`, `cpu_addr` and `cpu_wdata` stable until accepted.
- Addresses are not range-checked. Writes into 7D00–7D2F (inks, window registers, void pen) are legal and take effect at the video chip's next per-frame register load.

## Timing
- Reset values: `vid_phase` 0, `ram_addr` 0, `ram_wdata` 0, `ram_we` 0, `vid_data` 0, `cpu_rd_data` 0, `cpu_rd_valid` 0, `fifo_level` 0, `cpu_ready` 0 while `rst` is high.
- Reset mid-operation:
  - The FIFO is flushed and `rd_pending` is cleared.
  - A read in flight never produces `cpu_rd_valid`.
  - The first cycle after reset is phase 0.
- Video latency: address in cycle t (phase 0) → `vid_data` updated at the end of t+1 → stable for t+2 and t+3.
- CPU write latency, from the acceptance edge to `ram_we` high: 1 cycle if accepted at the end of a phase-0 cycle, else 2 cycles. Worst case with a full queue is 2·FIFO_DEPTH cycles.
- CPU read latency: issue in a phase-1 cycle (t) → `cpu_rd_valid` high in cycle t+2, i.e. the next phase-1 cycle.
- Throughput: at most 1 CPU command per 2 cycles.
- Pointer wrap: the FIFO pointers are $clog2(FIFO_DEPTH)+1 bits wide and wrap modulo 2·FIFO_DEPTH.

## Structure
- Package `vram_arb_pkg`:
  - `ADDR_W`, `DATA_W`.
  - The command typedef `{rd, addr, data}`.
  - Constants `VRAM_PIXEL_END = 15'h7CFF`, `VRAM_REG_BASE = 15'h7D00`, `VOID_PEN_POS = 15'h7D2F`.
- Sub-module `vram_cmd_fifo`: synchronous FIFO with level output, no bypass. The arbiter top holds the phase, slot mux, and capture registers.

## Test plan
- Reset then idle:
  - `vid_phase` alternates 0,1,0,…
  - With `vid_addr = 0x0010` and RAM[0x0010] = 0xA5, `vid_data = 0xA5` from the third cycle after reset and is never disturbed.
- Single write/read pair:
  - Write 0x3C to 0x7D05, then read 0x7D05 on the next accepted cycle.
  - `ram_we` is high in one phase-1 cycle only; `cpu_rd_valid` pulses with `cpu_rd_data = 0x3C`.
- Back-pressure:
  - Issue 6 back-to-back writes with DEPTH = 4.
  - `cpu_ready` drops once the level reaches 4; all 6 writes land in order, one per CPU slot.
  - Video reads in that window are unaffected.
- Push/pop same cycle at level 2 → level stays 2.
- Reset asserted in the cycle after a read issue → no `cpu_rd_valid`, `fifo_level = 0`, the next cycle is phase 0.
- Video/CPU collision: the CPU writes 0x7C00 while `vid_addr = 0x7C00`. The video slot returns old data; the following video slot returns the new data.

Source files
------------

// File: rtl/vram_port_arbiter_pkg.sv
// Shared widths, the queued CPU command format and VRAM map landmarks for the VRAM arbiter.
// No logic; types and constants only.
// Imported by the arbiter top, its command FIFO and the CPU bus interface.
package vram_arb_pkg;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 8;

  // One queued CPU access; reads ignore the data field.
  typedef struct packed {
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } vram_cmd_t;

  // Pixel memory ends here; the video chip's register block follows.
  localparam logic [ADDR_W-1:0] VRAM_PIXEL_END = 15'h7CFF;
  localparam logic [ADDR_W-1:0] VRAM_REG_BASE  = 15'h7D00;
  localparam logic [ADDR_W-1:0] VOID_PEN_POS   = 15'h7D2F;

endpackage

// File: rtl/vram_port_arbiter_if.sv
// CPU command bus into the VRAM arbiter: valid/ready command channel plus read return.
// Wires only, no latency.
// Commands stall while cpu_ready is low; read returns cannot be stalled.
interface vram_port_arbiter_if;
  import vram_arb_pkg::*;

  logic              cpu_valid;
  logic              cpu_rd;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ready;
  logic              cpu_rd_valid;
  logic [DATA_W-1:0] cpu_rd_data;

  // CPU side
  modport master (
    output cpu_valid, cpu_rd, cpu_addr, cpu_wdata,
    input  cpu_ready, cpu_rd_valid, cpu_rd_data
  );

  // Arbiter side
  modport slave (
    input  cpu_valid, cpu_rd, cpu_addr, cpu_wdata,
    output cpu_ready, cpu_rd_valid, cpu_rd_data
  );

endinterface

// File: rtl/vram_port_arbiter_cmd_fifo.sv
// Generic synchronous FIFO with occupancy output; the head entry is visible combinationally.
// A pushed entry is visible at the head one cycle after the push edge (no bypass).
// Pushes while full are dropped; the owner gates push with its ready signal.
module vram_cmd_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_vld,
  input  T                         push_dat,
  input  logic                     pop_vld,
  output T                         head_dat,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // One extra pointer bit separates full from empty; pointers wrap modulo 2*DEPTH.
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  T              mem [DEPTH];
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign level    = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (level == PW'(DEPTH));
  assign do_push  = push_vld && !full;
  assign do_pop   = pop_vld && !empty;
  assign head_dat = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset flushes the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Entry storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/vram_port_arbiter.sv
// Shares single-port VRAM: even cycles serve the video address, odd cycles run one queued CPU command.
// Video data lands 2 cycles after its address; CPU writes hit RAM 1-2 cycles after accept, reads return 2 cycles after issue.
// cpu_ready drops when the command queue is full or in reset; video slots never stall.
module vram_port_arbiter
  import vram_arb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        vid_phase,
  input  logic [ADDR_W-1:0]           vid_addr,
  output logic [DATA_W-1:0]           vid_data,
  vram_port_arbiter_if.slave          cpu,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [ADDR_W-1:0]           ram_addr,
  output logic [DATA_W-1:0]           ram_wdata,
  output logic                        ram_we,
  input  logic [DATA_W-1:0]           ram_rdata
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic              phase;
  logic              rd_pending;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  vram_cmd_t         push_cmd;
  vram_cmd_t         head;
  logic              fifo_empty;
  logic              push;
  logic              pop;

  assign cpu.cpu_ready    = !rst && (fifo_level < LVL_W'(FIFO_DEPTH));
  assign cpu.cpu_rd_valid = rd_valid_q;
  assign cpu.cpu_rd_data  = rd_data_q;
  assign vid_phase        = phase;

  assign push     = cpu.cpu_valid && cpu.cpu_ready;
  assign pop      = !rst && phase && !fifo_empty;
  assign push_cmd = '{rd: cpu.cpu_rd, addr: cpu.cpu_addr, data: cpu.cpu_wdata};

  vram_cmd_fifo #(
    .T     (vram_cmd_t),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (push),
    .push_dat (push_cmd),
    .pop_vld  (pop),
    .head_dat (head),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  // RAM port mux: video address in phase 0, queue head in phase 1, else hold the last drive.
  always_comb begin
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    ram_we    = 1'b0;
    if (rst) begin
      ram_addr  = '0;
      ram_wdata = '0;
    end else if (!phase) begin
      ram_addr = vid_addr;
    end else if (!fifo_empty) begin
      ram_addr = head.addr;
      if (!head.rd) begin
        ram_we    = 1'b1;
        ram_wdata = head.data;
      end
    end
  end

  // Slot phase and the held RAM drive used when a CPU slot goes unused.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      phase   <= !phase;
      addr_q  <= ram_addr;
      wdata_q <= ram_wdata;
    end
  end

  // Video capture: RAM data during a phase-1 cycle belongs to the preceding video address.
  always_ff @(posedge clk) begin
    if (rst) begin
      vid_data <= '0;
    end else if (phase) begin
      vid_data <= ram_rdata;
    end
  end

  // Read return: a read issued in phase 1 has its data on ram_rdata in the following phase 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pending <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      if (pop && head.rd) begin
        rd_pending <= 1'b1;
      end else if (!phase && rd_pending) begin
        rd_pending <= 1'b0;
        rd_data_q  <= ram_rdata;
        rd_valid_q <= 1'b1;
      end
    end
  end

endmodule
